// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encodings, op codes, widths and add/sub helper for calc_core
package calc_pkg;

    localparam int W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        READY  = 2'd2,
        SHOW   = 2'd3
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam logic [W-1:0] MAX_POS = 4'b0111;
    localparam logic [W-1:0] MAX_NEG = 4'b1000;

    typedef struct packed {
        logic [W-1:0] r;
        logic         ovf;
    } alu_res_t;

    // Wrapped result plus signed overflow; carry out is intentionally dropped.
    function automatic alu_res_t alu(input logic [W-1:0] a, input logic [W-1:0] b, input op_t op);
        alu_res_t res;
        if (op == OP_ADD) begin
            res.r   = a + b;
            res.ovf = (a[W-1] == b[W-1]) && (res.r[W-1] != a[W-1]);
        end else begin
            res.r   = a - b;
            res.ovf = (a[W-1] != b[W-1]) && (res.r[W-1] != a[W-1]);
        end
        return res;
    endfunction

endpackage

// File: rtl/calc_press_detect.sv
// rtl/calc_press_detect.sv - rising-edge press detector, previous sample resets to 1
module press_detect #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] level,
    output logic [N-1:0] press
);

    logic [N-1:0] prev;

    // Resetting to all-ones suppresses a press for a button held through reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '1;
        end else begin
            prev <= level;
        end
    end

    assign press = level & ~prev;

endmodule

// File: rtl/calc_core.sv
// rtl/calc_core.sv - 4-bit chained add/sub calculator core; CALC_SAT_EN selects saturating result
module calc_core
    import calc_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] DIN,
    input  logic         LOAD_A,
    input  logic         LOAD_B,
    input  logic         ADD,
    input  logic         SUB,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] R,
    output logic         OVF,
    output logic         RES_VALID
);

    state_t       state, state_n;
    logic [W-1:0] a_q, a_n, b_q, b_n, r_q, r_n;
    logic         ovf_q, ovf_n;
    logic [3:0]   press;
    logic [W-1:0] opnd;
    op_t          op;
    alu_res_t     res;
    logic [W-1:0] r_calc;

    press_detect #(.N(4)) u_press (
        .clk   (CLK),
        .rst   (RST),
        .level ({SUB, ADD, LOAD_B, LOAD_A}),
        .press (press)
    );

    // In SHOW the previous result becomes the left operand (chaining).
    assign opnd = (state == SHOW) ? r_q : a_q;
    assign op   = press[2] ? OP_ADD : OP_SUB;
    assign res  = alu(opnd, b_q, op);

`ifdef CALC_SAT_EN
    // On overflow the true result's sign is the sign of the left operand.
    assign r_calc = res.ovf ? (opnd[W-1] ? MAX_NEG : MAX_POS) : res.r;
`else
    assign r_calc = res.r;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            r_q   <= r_n;
            ovf_q <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        r_n     = r_q;
        ovf_n   = ovf_q;
        if (press[0]) begin
            a_n = DIN;
            if (state == SHOW) begin
                r_n     = '0;
                ovf_n   = 1'b0;
                state_n = HAVE_A;
            end else if (state == IDLE) begin
                state_n = HAVE_A;
            end
        end else if (press[1]) begin
            if (state != IDLE) begin
                b_n = DIN;
                if (state == SHOW) begin
                    r_n   = '0;
                    ovf_n = 1'b0;
                end
                state_n = READY;
            end
        end else if (press[2] || press[3]) begin
            if (state == READY || state == SHOW) begin
                a_n     = opnd;
                r_n     = r_calc;
                ovf_n   = res.ovf;
                state_n = SHOW;
            end
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign R         = r_q;
    assign OVF       = ovf_q;
    assign RES_VALID = (state == SHOW);

endmodule

// File: doc/calc_core.md
# calc_core

Sequential 4-bit two's-complement calculator core that sits directly upstream of the lab's display driver. Captures operands A and B from the switch bus on button presses, computes R = A+B or R = A−B with signed overflow detection, and supports chained operations where the previous result becomes the next A. Its A, B, R and OVF outputs feed the display driver's ports of the same names unchanged.

## Interface
Parameters:
- none (width fixed at 4; constants live in the package)

Ports:
- CLK  input  1  single system clock; all state updates on its rising edge
- RST  input  1  synchronous, active-high reset
- DIN  input  4  operand value from switches, two's complement
- LOAD_A  input  1  button level; a press loads A
- LOAD_B  input  1  button level; a press loads B
- ADD  input  1  button level; a press computes A+B
- SUB  input  1  button level; a press computes A−B
- A  output  4  registered operand A
- B  output  4  registered operand B
- R  output  4  registered result
- OVF  output  1  registered signed-overflow flag for R
- RES_VALID  output  1  high while in state SHOW

Buttons are already synchronised to CLK before this block.

## Operation
- Press = rising edge: button high this cycle, low in the registered previous sample. A held button produces exactly one press.
- Previous-sample registers reset to 1, so a button held through reset release produces no press.
- Priority when several presses land in one cycle: LOAD_A > LOAD_B > ADD > SUB. Only the highest press acts; the rest are dropped.
- States: IDLE, HAVE_A, READY, SHOW.
  - IDLE: LOAD_A → A<=DIN, go HAVE_A. LOAD_B, ADD and SUB are ignored.
  - HAVE_A: LOAD_A → reload A, stay. LOAD_B → B<=DIN, go READY. ADD and SUB are ignored.
  - READY: LOAD_A or LOAD_B → reload that operand, stay. ADD/SUB → compute from A, B; go SHOW.
  - SHOW: ADD/SUB → chain: A<=R, R<=R op B, OVF recomputed, stay SHOW. LOAD_A → A<=DIN, R<=0, OVF<=0, go HAVE_A. LOAD_B → B<=DIN, R<=0, OVF<=0, go READY.
- Arithmetic is 4-bit wrap-around; the carry out is discarded.
- Overflow rules:
  - ADD: A[3]==B[3] and R[3]!=A[3].
  - SUB: A[3]!=B[3] and R[3]!=A[3].
- R and OVF hold their values until the next compute or clear.

## Timing
- Reset values: A=0, B=0, R=0, OVF=0, RES_VALID=0, state IDLE.
- Press detected in cycle N → A/B/R/OVF/state updated at the edge ending cycle N. New values are visible in cycle N+1, so latency is 1 cycle from the button's first high cycle.
- RES_VALID rises in the same cycle R first shows a computed value.
- RST asserted in any state, including mid-chain in SHOW, clears all outputs at the next edge. RST has priority over every press.
- Back-to-back presses on consecutive cycles are impossible, because each button needs a low cycle between presses. Presses on different buttons in consecutive cycles are each honoured.

## Configuration
- CALC_SAT_EN defined: on overflow, R saturates to 4'b0111 if the true result is positive or 4'b1000 if negative. OVF is still 1.
- CALC_SAT_EN undefined: R takes the wrapped 4-bit result.
- OVF behaviour is identical in both builds.

## Structure
- Shared package calc_pkg holds:
  - state encodings: IDLE=2'd0, HAVE_A=2'd1, READY=2'd2, SHOW=2'd3
  - op select constants: OP_ADD, OP_SUB
  - width constant W=4
  - saturation limits MAX_POS=4'b0111, MAX_NEG=4'b1000
- One sub-module, press_detect: per-button previous-sample register with reset value 1, outputting a one-cycle press pulse. It is instantiated four times, or once as a 4-bit vector.

## Test plan
- LOAD_A with DIN=3, LOAD_B with DIN=4, ADD → R=0111, OVF=0, RES_VALID=1 one cycle after the ADD press.
- A=5, B=4, ADD → R=1001, OVF=1. With CALC_SAT_EN: R=0111, OVF=1.
- A=1000 (−8), B=0001, SUB → R=0111, OVF=1. With CALC_SAT_EN: R=1000, OVF=1.
- A=2, B=3, ADD then ADD → R=0101, OVF=0; then A=0101, R=1000, OVF=1 (wrap build).
- Hold ADD high 10 cycles in READY → exactly one compute. Press LOAD_B in IDLE, and ADD in HAVE_A → no output change.
- RST in SHOW → next cycle A=B=R=0, OVF=0, RES_VALID=0. Holding LOAD_A across RST release produces no load.
